serial_subtractor: RTL

//   Parametrised bit-serial subtractor: computes diff = a - b over WIDTH bits,
//   LSB first, one bit per clock, using a single full-subtractor cell and a

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Results are published only on the done edge and held until the next one.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [WIDTH-1:0] r_a_sr,     w_a_sr_nxt;
    logic [WIDTH-1:0] r_b_sr,     w_b_sr_nxt;
    logic [WIDTH-1:0] r_res,      w_res_nxt;
    logic             r_borrow,   w_borrow_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic [WIDTH-1:0] r_diff,     w_diff_nxt;
    logic             r_bor_out,  w_bor_out_nxt;
    logic             r_ovf,      w_ovf_nxt;
    logic             r_zero,     w_zero_nxt;

    logic             w_x, w_y, w_d, w_br;
    logic [WIDTH-1:0] w_res_shift;
    logic             w_last;

    // Full-subtractor cell on the current LSBs
    assign w_x         = r_a_sr[0];
    assign w_y         = r_b_sr[0];
    assign w_d         = w_x ^ w_y ^ r_borrow;
    assign w_br        = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_res_shift = {w_d, r_res[WIDTH-1:1]};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and output-register values
    always_comb begin
        w_state_nxt   = r_state;
        w_a_sr_nxt    = r_a_sr;
        w_b_sr_nxt    = r_b_sr;
        w_res_nxt     = r_res;
        w_borrow_nxt  = r_borrow;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_diff_nxt    = r_diff;
        w_bor_out_nxt = r_bor_out;
        w_ovf_nxt     = r_ovf;
        w_zero_nxt    = r_zero;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt  = S_SHIFT;
                    w_a_sr_nxt   = bus.a;
                    w_b_sr_nxt   = bus.b;
                    w_borrow_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_SHIFT: begin
                w_a_sr_nxt   = r_a_sr >> 1;
                w_b_sr_nxt   = r_b_sr >> 1;
                w_res_nxt    = w_res_shift;
                w_borrow_nxt = w_br;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (w_last) begin
                    // On the last bit x and y are the operand sign bits
                    w_state_nxt   = S_DONE;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_diff_nxt    = w_res_shift;
                    w_bor_out_nxt = w_br;
                    w_zero_nxt    = (w_res_shift == '0);
                    w_ovf_nxt     = (w_x ^ w_y) & (w_x ^ w_d);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_res     <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_diff    <= '0;
            r_bor_out <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a_sr    <= w_a_sr_nxt;
            r_b_sr    <= w_b_sr_nxt;
            r_res     <= w_res_nxt;
            r_borrow  <= w_borrow_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_diff    <= w_diff_nxt;
            r_bor_out <= w_bor_out_nxt;
            r_ovf     <= w_ovf_nxt;
            r_zero    <= w_zero_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_bor_out;
    assign bus.overflow   = r_ovf;
    assign bus.zero       = r_zero;
endmodule
